// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//
// Single-clock FIFO with configurable width and depth, programmable
// almost-full / almost-empty thresholds, an occupancy count, sticky
// overflow/underflow flags and an optional first-word-fall-through read port.
//
// Parameters:
//   DATA_WIDTH  word width in bits (>= 1)
//   DEPTH       number of entries, power of two (>= 2)
//   AFULL_TH    almost_full when count >= AFULL_TH   (1..DEPTH)
//   AEMPTY_TH   almost_empty when count <= AEMPTY_TH (0..DEPTH-1)
//   FWFT        0 = registered dout loaded on read, 1 = first-word-fall-through
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           asynchronous active-high reset
//   din           write data
//   wr_en         write request
//   rd_en         read request (pop/acknowledge in FWFT mode)
//   clr_err       synchronous clear of the sticky error flags
//   dout          read data
//   empty         count == 0
//   full          count == DEPTH
//   almost_empty  count <= AEMPTY_TH
//   almost_full   count >= AFULL_TH
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// -----------------------------------------------------------------------------
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = DEPTH - 1,
  parameter int AEMPTY_TH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       din,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(DEPTH);

  // Thresholds sized to the count register so the decodes compare like widths.
  localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_V  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_V = (AW+1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;

  // Status flags decode the registered count only, so they never depend
  // combinationally on the request inputs.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_V);
  assign almost_empty = (count <= AEMPTY_V);
  assign almost_full  = (count >= AFULL_V);

  // A write into a full FIFO is still taken when a read frees a slot in the
  // same cycle; a read of an empty FIFO is never bypassed from din.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_en);

  // Storage is deliberately left unreset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr_acc && !rd_acc) begin
      count <= count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count <= count - 1'b1;
    end
  end

  // Sticky error flags; clr_err wins over a set in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of the queue is always presented; meaningless while empty.
      assign dout = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      // Registered read port: holds its value until the next accepted read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end

      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_sync_fifo
//
// Drives two FIFO instances from the same directed stimulus: dut_a uses the
// default standard-read configuration, dut_b uses FWFT with thresholds 5/2.
// A queue-based reference model tracks the contents and sticky flags; a
// compare process checks both instances against it on every falling edge,
// and literal expectations along the directed sequence pin the model.
// -----------------------------------------------------------------------------
module tb_param_sync_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;
  logic       clr_err;

  logic [7:0] dout_a;
  logic       empty_a, full_a, aempty_a, afull_a, ovf_a, unf_a;
  logic [3:0] count_a;

  logic [7:0] dout_b;
  logic       empty_b, full_b, aempty_b, afull_b, ovf_b, unf_b;
  logic [3:0] count_b;

  int errors;
  int checks;
  bit checking_on;
  int cmp_n;

  logic [7:0] m_q[$];
  logic [7:0] m_dout;
  bit         m_ovf;
  bit         m_unf;
  bit         m_full;
  bit         m_empty;

  param_sync_fifo dut_a (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .dout         (dout_a),
    .empty        (empty_a),
    .full         (full_a),
    .almost_empty (aempty_a),
    .almost_full  (afull_a),
    .count        (count_a),
    .overflow     (ovf_a),
    .underflow    (unf_a)
  );

  param_sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .AFULL_TH   (5),
    .AEMPTY_TH  (2),
    .FWFT       (1)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .dout         (dout_b),
    .empty        (empty_b),
    .full         (full_b),
    .almost_empty (aempty_b),
    .almost_full  (afull_b),
    .count        (count_b),
    .overflow     (ovf_b),
    .underflow    (unf_b)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of requests, waits for the committing edge, then
  // returns to idle 2 ns after it so outputs can be inspected.
  task automatic applyStimulus(input logic w, input logic r, input logic c,
                               input logic [7:0] d);
    wr_en   = w;
    rd_en   = r;
    clr_err = c;
    din     = d;
    @(posedge clk);
    #2;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    din     = 8'h00;
  endtask

  // Reference model: a plain queue of stored words plus the sticky flags,
  // updated from the requests seen at each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      m_full  = (m_q.size() == 8);
      m_empty = (m_q.size() == 0);
      if (clr_err) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (wr_en && m_full && !rd_en) m_ovf = 1'b1;
        if (rd_en && m_empty) m_unf = 1'b1;
      end
      if (rd_en && !m_empty) m_dout = m_q.pop_front();
      if (wr_en && (!m_full || rd_en)) m_q.push_back(din);
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (checking_on) begin
      cmp_n = m_q.size();
      checkOutput("a_count",  32'(count_a),  32'(cmp_n));
      checkOutput("a_empty",  32'(empty_a),  32'(cmp_n == 0));
      checkOutput("a_full",   32'(full_a),   32'(cmp_n == 8));
      checkOutput("a_afull",  32'(afull_a),  32'(cmp_n >= 7));
      checkOutput("a_aempty", 32'(aempty_a), 32'(cmp_n <= 1));
      checkOutput("a_ovf",    32'(ovf_a),    32'(m_ovf));
      checkOutput("a_unf",    32'(unf_a),    32'(m_unf));
      checkOutput("a_dout",   32'(dout_a),   32'(m_dout));
      checkOutput("b_count",  32'(count_b),  32'(cmp_n));
      checkOutput("b_empty",  32'(empty_b),  32'(cmp_n == 0));
      checkOutput("b_full",   32'(full_b),   32'(cmp_n == 8));
      checkOutput("b_afull",  32'(afull_b),  32'(cmp_n >= 5));
      checkOutput("b_aempty", 32'(aempty_b), 32'(cmp_n <= 2));
      checkOutput("b_ovf",    32'(ovf_b),    32'(m_ovf));
      checkOutput("b_unf",    32'(unf_b),    32'(m_unf));
      if (cmp_n > 0) begin
        checkOutput("b_dout", 32'(dout_b), 32'(m_q[0]));
      end
    end
  end

  // Directed sequence with hand-computed literal expectations.
  initial begin
    logic [7:0] exp_byte;
    errors      = 0;
    checks      = 0;
    checking_on = 1'b0;
    rst         = 1'b1;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    clr_err     = 1'b0;
    din         = 8'h00;

    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    checking_on = 1'b1;

    checkOutput("rst_count",  32'(count_a),  32'd0);
    checkOutput("rst_empty",  32'(empty_a),  32'd1);
    checkOutput("rst_aempty", 32'(aempty_a), 32'd1);
    checkOutput("rst_full",   32'(full_a),   32'd0);
    checkOutput("rst_dout",   32'(dout_a),   32'h00);
    checkOutput("rst_ovf",    32'(ovf_a),    32'd0);
    checkOutput("rst_unf",    32'(unf_a),    32'd0);

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(17 * i));
      if (i == 1) begin
        checkOutput("fwft_first_dout",  32'(dout_b),  32'h11);
        checkOutput("fwft_first_empty", 32'(empty_b), 32'd0);
      end
      if (i == 4) checkOutput("b_afull_at4", 32'(afull_b), 32'd0);
      if (i == 5) checkOutput("b_afull_at5", 32'(afull_b), 32'd1);
      if (i == 6) checkOutput("a_afull_at6", 32'(afull_a), 32'd0);
      if (i == 7) begin
        checkOutput("a_afull_at7", 32'(afull_a), 32'd1);
        checkOutput("a_full_at7",  32'(full_a),  32'd0);
      end
    end
    checkOutput("fill_full",  32'(full_a),  32'd1);
    checkOutput("fill_count", 32'(count_a), 32'd8);

    // Rejected write while full
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h99);
    checkOutput("ovf_set",   32'(ovf_a),   32'd1);
    checkOutput("ovf_count", 32'(count_a), 32'd8);

    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("ovf_clr", 32'(ovf_a), 32'd0);

    // Simultaneous read and write while full
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
    checkOutput("sim_dout",  32'(dout_a),  32'h11);
    checkOutput("sim_count", 32'(count_a), 32'd8);
    checkOutput("sim_ovf",   32'(ovf_a),   32'd0);

    // Drain: 0x22..0x88 then the wrapped 0xAA
    for (int i = 0; i < 8; i++) begin
      if (i < 7) exp_byte = 8'(17 * (i + 2));
      else       exp_byte = 8'hAA;
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("drain_dout", 32'(dout_a), 32'(exp_byte));
    end
    checkOutput("drain_empty", 32'(empty_a), 32'd1);

    // Read while empty
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("unf_set",  32'(unf_a),  32'd1);
    checkOutput("unf_hold", 32'(dout_a), 32'hAA);

    // Clear takes priority over a same-cycle underflow
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    checkOutput("clr_prio", 32'(unf_a), 32'd0);

    // Empty with both requests: write accepted, read rejected
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h5C);
    checkOutput("ewr_count", 32'(count_a), 32'd1);
    checkOutput("ewr_unf",   32'(unf_a),   32'd1);
    checkOutput("ewr_doutb", 32'(dout_b),  32'h5C);
    checkOutput("ewr_emptb", 32'(empty_b), 32'd0);
    checkOutput("ewr_douta", 32'(dout_a),  32'hAA);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("pop_emptyb", 32'(empty_b), 32'd1);
    checkOutput("pop_douta",  32'(dout_a),  32'h5C);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Load five words then reset between edges
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
    end
    checkOutput("pre_rst_count", 32'(count_a), 32'd5);
    rst = 1'b1;
    #1;
    checkOutput("async_count_a", 32'(count_a), 32'd0);
    checkOutput("async_empty_a", 32'(empty_a), 32'd1);
    checkOutput("async_count_b", 32'(count_b), 32'd0);
    checkOutput("async_empty_b", 32'(empty_b), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h03);
    checkOutput("post_rst_doutb", 32'(dout_b), 32'h03);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("post_rst_douta", 32'(dout_a), 32'h03);
    checkOutput("post_rst_empty", 32'(empty_a), 32'd1);

    // Interleaved traffic to exercise pointer wrap against the model
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, (i % 3) != 0, 1'b0, 8'(8'hC0 + i));
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    end

    @(negedge clk);
    #1;
    checking_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO, the next generation of the board-level 8-bit sync FIFO. It generalises data width and depth and adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between any two same-clock producers and consumers in the NPC design and can also be wired to switches and LEDs for board bring-up.

## Interface
- DATA_WIDTH, default 8: word width in bits, ≥1.
- DEPTH, default 8: number of entries; power of two, ≥2.
- AFULL_TH, default DEPTH-1: `almost_full` is asserted when `count >= AFULL_TH`; range 1..DEPTH.
- AEMPTY_TH, default 1: `almost_empty` is asserted when `count <= AEMPTY_TH`; range 0..DEPTH-1.
- FWFT, default 0: 0 = standard read (registered `dout`); 1 = first-word-fall-through.
- Let AW = $clog2(DEPTH).

Ports (direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- clr_err  in  1  synchronous clear of the sticky error flags.
- dout  out  DATA_WIDTH  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- almost_full  out  1  count ≥ AFULL_TH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

## Operation
- State:
  - Storage array `mem[DEPTH]` of DATA_WIDTH bits.
  - Pointers `wr_ptr` and `rd_ptr`, AW bits each; they wrap naturally from DEPTH-1 to 0.
  - `count` register.
  - `dout` register (used only when FWFT=0).
- Read acceptance: `rd_acc = rd_en & !empty`.
- Write acceptance: `wr_acc = wr_en & (!full | rd_en)`. A write while full is accepted only together with a read in the same cycle (the read always succeeds because full implies not empty).
- Empty with simultaneous wr_en and rd_en: the write is accepted and the read is rejected (no bypass), so `underflow` sets.
- On `wr_acc`: `mem[wr_ptr] <= din`, then `wr_ptr` increments.
- On `rd_acc`: `rd_ptr` increments.
  - FWFT=0: `dout <= mem[rd_ptr]`.
  - FWFT=1: `dout = mem[rd_ptr]` continuously. It is valid whenever `empty` is 0, and `rd_en` acts as the pop/acknowledge.
- count update: +1 on write only, −1 on read only, unchanged when both or neither are accepted.
- When not reading, `dout` holds its last value (FWFT=0). In FWFT=1 while empty, `dout` is don't-care.
- Error flags:
  - `overflow` sets on `wr_en & full & !rd_en`.
  - `underflow` sets on `rd_en & empty`.
  - Both stay set until `clr_err`.
  - `clr_err` has priority over a same-cycle set: the flag reads 0 on the next cycle.
- All status outputs (`empty`, `full`, `almost_empty`, `almost_full`) are combinational decodes of the `count` register only, never of `wr_en` or `rd_en`.

## Timing
- Reset (async assert, release synchronous to clk): `wr_ptr = rd_ptr = 0`, `count = 0`, `dout = 0`, `overflow = underflow = 0`.
  - Resulting outputs: `empty = 1`, `full = 0`, `almost_empty = 1` (since AEMPTY_TH ≥ 0), `almost_full = 0` unless AFULL_TH = 0 (not allowed).
  - `mem` is not reset.
- Reset mid-operation discards all contents immediately. The first write after release lands at `mem[0]`.
- Write latency: the word written at edge N is readable from edge N.
  - FWFT=1: it appears on `dout` and `empty` falls after edge N.
  - FWFT=0: a `rd_en` sampled at edge N+1 loads it into `dout` after edge N+1.
- Standard-mode read latency: 1 cycle from the `rd_en` edge to `dout`.
- Flags and count change only after the clock edge that commits an accepted operation.
- Full with simultaneous rd_en and wr_en: `count` stays at DEPTH, the oldest word is popped, the new word is stored in the freed slot, and no overflow occurs.

## Test plan
- Reset with defaults: after `rst` pulse -> `count = 0`, `empty = 1`, `almost_empty = 1`, `full = 0`, `dout = 0`, both error flags 0.
- Fill and drain (DEPTH=8, FWFT=0): write 0x11..0x88 on 8 cycles -> `full = 1` and `almost_full = 1` from count 7. Then 8 reads -> `dout` = 0x11..0x88 one cycle after each rd_en, ending with `empty = 1`.
- Errors: 9th write while full -> `overflow = 1` and `count` stays 8. Read while empty -> `underflow = 1`. `clr_err` pulse -> both 0 the next cycle.
- Simultaneous at full: full FIFO, `wr_en = rd_en = 1`, `din = 0xAA` -> 0x11 is read out, `count = 8`, no overflow. 0xAA emerges last after 8 further reads, confirming pointer wrap.
- FWFT=1: write 0x5C into an empty FIFO -> `dout = 0x5C` and `empty = 0` with no rd_en. `rd_en` for 1 cycle -> `empty = 1`.
- Async reset mid-stream: assert `rst` between edges with count 5 -> `count = 0` and `empty = 1` before the next edge. Then write 0x3 and read -> `dout = 0x3`.
